// File: rtl/ascon_pin_host.sv
// Host-side master for the ASCON core pin bus: serializes 128-bit fields MSB-first,
// strobes start, and reassembles the core's serial result into response words.
module ascon_pin_host #(
  parameter int DATA_W      = 128,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              err_timeout,
  output logic              pin_sdi,
  output logic              pin_sdv,
  output logic [2:0]        pin_sel,
  output logic              pin_start,
  input  logic              pin_sdo,
  input  logic              pin_sov,
  input  logic              pin_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam int CNT_W = $clog2(DATA_W + 1);
  // The window is widened by the synchronizer depth so the core gets the full TIMEOUT at its pins.
  localparam int TMO_LIMIT = TIMEOUT + SYNC_STAGES - 1;
  localparam int TMO_W     = $clog2(TMO_LIMIT + 1);

  logic [2:0]             state_r;
  logic [2:0]             state_nxt_s;
  logic [DATA_W-1:0]      tx_sr_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_W-1:0]      rx_sr_r;
  logic [CNT_W-1:0]       rx_cnt_r;
  logic [TMO_W-1:0]       tmo_cnt_r;
  logic [SYNC_STAGES-1:0] sov_sync_r;
  logic [SYNC_STAGES-1:0] sdo_sync_r;
  logic [SYNC_STAGES-1:0] done_sync_r;

  logic              sov_s;
  logic              sdo_s;
  logic              done_s;
  logic              tmo_hit_s;
  logic [DATA_W-1:0] rx_word_s;
  logic [CNT_W-1:0]  rx_cnt_nxt_s;
  logic [CNT_W-1:0]  shamt_s;
  logic [DATA_W-1:0] rx_align_s;

  assign sov_s   = sov_sync_r[SYNC_STAGES-1];
  assign sdo_s   = sdo_sync_r[SYNC_STAGES-1];
  assign done_s  = done_sync_r[SYNC_STAGES-1];
  assign pin_sdi = tx_sr_r[DATA_W-1];

  assign rx_word_s    = sov_s ? {rx_sr_r[DATA_W-2:0], sdo_s} : rx_sr_r;
  assign rx_cnt_nxt_s = sov_s ? (rx_cnt_r + CNT_W'(1)) : rx_cnt_r;
  assign shamt_s      = CNT_W'(DATA_W) - rx_cnt_nxt_s;
  assign rx_align_s   = rx_word_s << shamt_s;
  assign tmo_hit_s    = !sov_s && (tmo_cnt_r == TMO_W'(TMO_LIMIT));

  // Input synchronizers for the core's result pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sov_sync_r  <= '0;
      sdo_sync_r  <= '0;
      done_sync_r <= '0;
    end else begin
      sov_sync_r  <= {sov_sync_r[SYNC_STAGES-2:0], pin_sov};
      sdo_sync_r  <= {sdo_sync_r[SYNC_STAGES-2:0], pin_sdo};
      done_sync_r <= {done_sync_r[SYNC_STAGES-2:0], pin_done};
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) state_nxt_s = cmd_op ? ST_START : ST_SHIFT;
        else           state_nxt_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (bit_cnt_r == CNT_W'(1)) state_nxt_s = ST_GAP;
        else                        state_nxt_s = ST_SHIFT;
      end
      ST_GAP:   state_nxt_s = ST_IDLE;
      ST_START: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s || tmo_hit_s) state_nxt_s = ST_IDLE;
        else                     state_nxt_s = ST_WAIT;
      end
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and the status/strobe outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      pin_sdv   <= 1'b0;
      pin_start <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cmd_ready <= (state_nxt_s == ST_IDLE);
      busy      <= (state_nxt_s != ST_IDLE);
      pin_sdv   <= (state_nxt_s == ST_SHIFT);
      pin_start <= (state_nxt_s == ST_START);
    end
  end

  // Serializer, deserializer, timeout and response datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr_r     <= '0;
      bit_cnt_r   <= '0;
      pin_sel     <= 3'd0;
      rx_sr_r     <= '0;
      rx_cnt_r    <= '0;
      tmo_cnt_r   <= '0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      rsp_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            err_timeout <= 1'b0;
            if (!cmd_op) begin
              tx_sr_r   <= cmd_data;
              pin_sel   <= cmd_sel;
              bit_cnt_r <= CNT_W'(DATA_W);
            end else begin
              rx_cnt_r  <= '0;
              tmo_cnt_r <= '0;
            end
          end
        end
        ST_SHIFT: begin
          tx_sr_r   <= {tx_sr_r[DATA_W-2:0], 1'b0};
          bit_cnt_r <= bit_cnt_r - CNT_W'(1);
        end
        ST_START: tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        ST_WAIT: begin
          rx_sr_r   <= rx_word_s;
          tmo_cnt_r <= sov_s ? '0 : (tmo_cnt_r + TMO_W'(1));
          if (done_s) begin
            // A word completing alongside done is the last one; a partial word is left-aligned.
            if (rx_cnt_nxt_s != '0) begin
              rsp_valid <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_data  <= rx_align_s;
            end
            rx_cnt_r <= '0;
          end else if (rx_cnt_nxt_s == CNT_W'(DATA_W)) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rx_word_s;
            rx_cnt_r  <= '0;
          end else if (tmo_hit_s) begin
            err_timeout <= 1'b1;
            rx_cnt_r    <= '0;
          end else begin
            rx_cnt_r <= rx_cnt_nxt_s;
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_pin_host.sv
// Directed bench for ascon_pin_host: a queue-based model of the expected serial stream
// and response words is checked every cycle, plus literal expectations from the test plan.
module tb_ascon_pin_host;
  localparam int DW  = 128;
  localparam int TMO = 100;
  localparam int SS  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_op = 1'b0;
  logic [2:0]    cmd_sel = 3'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          err_timeout;
  logic          pin_sdi;
  logic          pin_sdv;
  logic [2:0]    pin_sel;
  logic          pin_start;
  logic          pin_sdo = 1'b0;
  logic          pin_sov = 1'b0;
  logic          pin_done = 1'b0;

  always #5 clk = ~clk;

  ascon_pin_host #(.DATA_W(DW), .TIMEOUT(TMO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy), .err_timeout(err_timeout), .pin_sdi(pin_sdi),
    .pin_sdv(pin_sdv), .pin_sel(pin_sel), .pin_start(pin_start), .pin_sdo(pin_sdo),
    .pin_sov(pin_sov), .pin_done(pin_done)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rsp_t;

  int            pass_cnt = 0;
  int            tot_cnt  = 0;
  bit            exp_bits[$];
  logic [2:0]    exp_sel = 3'd0;
  rsp_t          exp_rsp[$];
  int            rsp_seen = 0;
  logic [DW-1:0] last_rsp_data = '0;
  logic          last_rsp_last = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    tot_cnt++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Per-cycle compare of the DUT against the expected bit stream and response queue.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      chk1("ready_vs_busy", cmd_ready, ~busy);
      if (pin_sdv) begin
        if (exp_bits.size() == 0) fail_now("unexpected_sdv", "pin_sdv high with no field pending");
        else begin
          chk1("sdi_bit", pin_sdi, exp_bits.pop_front());
          chki("sdv_sel", int'(pin_sel), int'(exp_sel));
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        last_rsp_data = rsp_data;
        last_rsp_last = rsp_last;
        if (exp_rsp.size() == 0) fail_now("unexpected_rsp", "rsp_valid with no response expected");
        else begin
          e = exp_rsp.pop_front();
          chkw("rsp_data", rsp_data, e.data);
          chk1("rsp_last", rsp_last, e.last);
        end
      end else begin
        chk1("rsp_last_idle", rsp_last, 1'b0);
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [2:0] sel, input logic [DW-1:0] data);
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) fail_now("wait_ready", "cmd_ready never rose");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] sel, input logic [DW-1:0] data, input bit hold);
    int n = 0;
    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(data[i]);
    exp_sel = sel;
    send_cmd(1'b0, sel, data);
    chk1("err_after_cmd", err_timeout, 1'b0);
    if (hold) begin
      cmd_valid = 1'b1;
      cmd_data  = ~data;
      cmd_sel   = sel ^ 3'd7;
    end
    @(negedge clk);
    while (pin_sdv && n < DW + 10) begin
      n++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chki("sdv_len", n, DW);
    chk1("gap_ready", cmd_ready, 1'b0);
    chki("gap_sel", int'(pin_sel), int'(sel));
    @(negedge clk);
    chk1("idle_ready", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // Model: split the bit stream into DW-bit words, last word left-aligned and flagged last.
  task automatic model_rsp(input logic [2*DW-1:0] stream, input int nbits);
    rsp_t r;
    int full = nbits / DW;
    int rem  = nbits % DW;
    for (int f = 0; f < full; f++) begin
      r.data = stream[2*DW-1-DW*f -: DW];
      r.last = (rem == 0) && (f == full - 1);
      exp_rsp.push_back(r);
    end
    if (rem > 0) begin
      r.data = stream[2*DW-1-DW*full -: DW] & ({DW{1'b1}} << (DW - rem));
      r.last = 1'b1;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic do_run(input logic [2*DW-1:0] stream, input int nbits);
    int n = 0;
    model_rsp(stream, nbits);
    send_cmd(1'b1, 3'd0, '0);
    @(negedge clk);
    chk1("start_pulse", pin_start, 1'b1);
    @(negedge clk);
    chk1("start_one_cycle", pin_start, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      pin_sov  = 1'b1;
      pin_sdo  = stream[2*DW-1-i];
      pin_done = (i == nbits - 1);
    end
    @(posedge clk); #1;
    pin_sov = 1'b0;
    pin_sdo = 1'b0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("run_end", "busy stuck after pin_done");
    @(negedge clk);
    pin_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    int c;
    int base;
    repeat (3) @(negedge clk);
    chk1("rst_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_sdv", pin_sdv, 1'b0);
    chk1("rst_sdi", pin_sdi, 1'b0);
    chk1("rst_start", pin_start, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chkw("rst_rsp_data", rsp_data, '0);
    chk1("rst_err", err_timeout, 1'b0);
    chki("rst_sel", int'(pin_sel), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    do_load(3'd1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
    do_load(3'd5, 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0, 1'b1);
    chki("sel_holds", int'(pin_sel), 5);

    base = rsp_seen;
    do_run({32{8'hA5}}, 256);
    chki("rsp_count_256", rsp_seen - base, 2);
    chkw("rsp_lit_256", last_rsp_data, {16{8'hA5}});
    chk1("rsp_last_256", last_rsp_last, 1'b1);

    base = rsp_seen;
    do_run({40'hFF00FF00FF, 216'd0}, 40);
    chki("rsp_count_40", rsp_seen - base, 1);
    chkw("rsp_lit_40", last_rsp_data, {40'hFF00FF00FF, 88'h0});
    chk1("rsp_last_40", last_rsp_last, 1'b1);

    base = rsp_seen;
    send_cmd(1'b1, 3'd0, '0);
    @(negedge clk);
    chk1("tmo_start", pin_start, 1'b1);
    c = 0;
    while (!err_timeout && c < 400) begin
      @(negedge clk);
      c++;
    end
    chki("tmo_cycle", c, TMO + SS);
    chk1("tmo_busy", busy, 1'b0);
    chk1("tmo_ready", cmd_ready, 1'b1);
    repeat (5) @(negedge clk);
    chk1("tmo_sticky", err_timeout, 1'b1);
    chki("tmo_no_rsp", rsp_seen - base, 0);
    @(posedge clk); #1;
    do_load(3'd2, 128'hFFFF_0000_AAAA_5555_C3C3_3C3C_0F0F_F0F0, 1'b0);

    for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(1'b1);
    exp_sel = 3'd6;
    send_cmd(1'b0, 3'd6, {DW{1'b1}});
    repeat (60) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk1("arst_sdv", pin_sdv, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_ready", cmd_ready, 1'b1);
    exp_bits.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("rel_ready", cmd_ready, 1'b1);
    chk1("rel_busy", busy, 1'b0);
    @(posedge clk); #1;
    do_load(3'd3, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0);

    chki("bits_drained", exp_bits.size(), 0);
    chki("rsp_drained", exp_rsp.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
